// File: rtl/reg_file_arbiter_if.sv
// Bus bundle between the two protocol slaves, the register-file arbiter
// and the single-port register memory.
interface reg_file_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              i2c_req;
  logic              i2c_we;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic              i2c_ack;
  logic [DATA_W-1:0] i2c_rdata;

  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_ack;
  logic [DATA_W-1:0] spi_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and memory side
  modport master (
    output i2c_req, i2c_we, i2c_addr, i2c_wdata,
    input  i2c_ack, i2c_rdata,
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_ack, spi_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
    output i2c_ack, i2c_rdata,
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_ack, spi_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port register memory
// between the I2C and SPI register slaves; one access every 4 cycles.
module reg_file_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              take;
  logic              pick_spi;
  logic              clash;
  logic              last;
  logic              i2c_ack;
  logic              spi_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] i2c_rdata;
  logic [DATA_W-1:0] spi_rdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick_spi  = 1'b0;
    clash     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i2c_req || bus.spi_req) begin
          take      = 1'b1;
          clash     = bus.i2c_req && bus.spi_req;
          // On contention the port that did not win last time goes next
          pick_spi  = clash ? ~last : bus.spi_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The memory command registers double as the captured request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      owner        <= 1'b0;
      last         <= 1'b1;
      conflict_cnt <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i2c_ack      <= 1'b0;
      spi_ack      <= 1'b0;
      i2c_rdata    <= '0;
      spi_rdata    <= '0;
    end else begin
      i2c_ack <= 1'b0;
      spi_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            busy      <= 1'b1;
            owner     <= pick_spi;
            last      <= pick_spi;
            mem_en    <= 1'b1;
            mem_we    <= pick_spi ? bus.spi_we    : bus.i2c_we;
            mem_addr  <= pick_spi ? bus.spi_addr  : bus.i2c_addr;
            mem_wdata <= pick_spi ? bus.spi_wdata : bus.i2c_wdata;
            if (clash) conflict_cnt <= sat_inc(conflict_cnt);
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        WAIT: begin
          if (owner) begin
            spi_rdata <= bus.mem_rdata;
            spi_ack   <= 1'b1;
          end else begin
            i2c_rdata <= bus.mem_rdata;
            i2c_ack   <= 1'b1;
          end
        end
        ACK:     busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

  assign bus.i2c_ack   = i2c_ack;
  assign bus.spi_ack   = spi_ack;
  assign bus.i2c_rdata = i2c_rdata;
  assign bus.spi_rdata = spi_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: transaction-schedule model plus directed
// scenarios with hand-computed expectations.
module tb_reg_file_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic             owner;
  logic [CNT_W-1:0] conflict_cnt;

  reg_file_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_file_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .owner        (owner),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register memory: synchronous, read-first
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each granted access occupies cycles T+1..T+3 after its grant cycle T
  int         m_cyc = 0;
  int         m_t = 0;
  bit         m_txn = 0;
  bit         m_last = 1;
  bit         m_spi = 0;
  bit         m_we = 0;
  logic [7:0] m_addr = 0;
  logic [7:0] m_wdata = 0;
  logic [7:0] m_rd = 0;
  logic [7:0] m_i2c_rd = 0;
  logic [7:0] m_spi_rd = 0;
  int         m_cnt = 0;
  logic [7:0] m_mem [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txn    = 0;
      m_last   = 1;
      m_cnt    = 0;
      m_i2c_rd = 0;
      m_spi_rd = 0;
    end else begin
      if (m_txn && m_cyc - m_t == 1) begin
        m_rd = m_mem[m_addr];
        if (m_we) m_mem[m_addr] = m_wdata;
      end
      if (m_txn && m_cyc - m_t == 2) begin
        if (m_spi) m_spi_rd = m_rd;
        else       m_i2c_rd = m_rd;
      end
      if ((!m_txn || m_cyc - m_t >= 4) && (bus.i2c_req || bus.spi_req)) begin
        if (bus.i2c_req && bus.spi_req) begin
          m_spi = !m_last;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          m_spi = bus.spi_req;
        end
        m_last  = m_spi;
        m_we    = m_spi ? bus.spi_we    : bus.i2c_we;
        m_addr  = m_spi ? bus.spi_addr  : bus.i2c_addr;
        m_wdata = m_spi ? bus.spi_wdata : bus.i2c_wdata;
        m_txn   = 1;
        m_t     = m_cyc;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    int   d;
    logic e_busy;
    logic e_en;
    d      = m_cyc - m_t;
    e_busy = m_txn && d >= 1 && d <= 3;
    e_en   = m_txn && d == 1;
    check("busy",      busy,          e_busy);
    check("mem_en",    bus.mem_en,    e_en);
    check("mem_we",    bus.mem_we,    e_en && m_we);
    check("i2c_ack",   bus.i2c_ack,   e_busy && d == 3 && !m_spi);
    check("spi_ack",   bus.spi_ack,   e_busy && d == 3 && m_spi);
    check("i2c_rdata", bus.i2c_rdata, m_i2c_rd);
    check("spi_rdata", bus.spi_rdata, m_spi_rd);
    check("conflict_cnt", conflict_cnt, m_cnt);
    if (e_busy) check("owner", owner, m_spi);
    if (e_en) begin
      check("mem_addr",  bus.mem_addr,  m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
  end

  // Issue one request from the current cycle and hold it until its ack
  task automatic txn(input bit spi, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                     input int exp_lat, output logic [7:0] rd);
    bit got;
    if (spi) begin
      bus.spi_req = 1; bus.spi_we = we; bus.spi_addr = addr; bus.spi_wdata = wdata;
    end else begin
      bus.i2c_req = 1; bus.i2c_we = we; bus.i2c_addr = addr; bus.i2c_wdata = wdata;
    end
    got = 0;
    rd  = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (exp_lat == 3 && i == 1) begin
        check("issue mem_en",   bus.mem_en,   1);
        check("issue mem_addr", bus.mem_addr, addr);
      end
      if (spi ? bus.spi_ack : bus.i2c_ack) begin
        got = 1;
        check("ack latency", i, exp_lat);
        rd = spi ? bus.spi_rdata : bus.i2c_rdata;
      end
    end
    if (!got) check("ack timeout", 0, 1);
    @(posedge clk); #1;
    if (spi) bus.spi_req = 0;
    else     bus.i2c_req = 0;
  endtask

  // Both ports request continuously for n accesses
  task automatic contend(input int n, input bit first_spi);
    int acks;
    int cyc;
    int cyc_last;
    acks = 0; cyc = 0; cyc_last = 0;
    bus.i2c_req = 1; bus.i2c_we = 0; bus.i2c_addr = 8'h10; bus.i2c_wdata = 8'h00;
    bus.spi_req = 1; bus.spi_we = 1; bus.spi_addr = 8'h02; bus.spi_wdata = 8'h77;
    while (acks < n && cyc < n * 4 + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.i2c_ack || bus.spi_ack) begin
        check("alternating owner", bus.spi_ack, first_spi ^ (acks % 2));
        if (acks > 0) check("ack spacing", cyc - cyc_last, 4);
        cyc_last = cyc;
        acks++;
      end
    end
    check("contention acks", acks, n);
    @(posedge clk); #1;
    bus.i2c_req = 0;
    bus.spi_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    for (int k = 0; k < 256; k++) begin
      mem[k]   = '0;
      m_mem[k] = '0;
    end
    bus.mem_rdata = '0;
    bus.i2c_req = 0; bus.i2c_we = 0; bus.i2c_addr = '0; bus.i2c_wdata = '0;
    bus.spi_req = 0; bus.spi_we = 0; bus.spi_addr = '0; bus.spi_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    check("reset busy",     busy,          0);
    check("reset owner",    owner,         0);
    check("reset cnt",      conflict_cnt,  0);
    check("reset mem_en",   bus.mem_en,    0);
    check("reset i2c_ack",  bus.i2c_ack,   0);
    check("reset spi_rdata", bus.spi_rdata, 0);
    @(posedge clk); #1;

    txn(0, 1, 8'h10, 8'h3C, 3, rd_a);
    check("write returns old value", rd_a, 8'h00);
    txn(1, 0, 8'h10, 8'h00, 3, rd_b);
    check("spi read after write", rd_b, 8'h3C);
    check("i2c_rdata unchanged", bus.i2c_rdata, 8'h00);

    fork
      txn(0, 0, 8'h01, 8'h00, 3, rd_a);
      txn(1, 0, 8'h02, 8'h00, 7, rd_b);
    join
    check("first conflict count", conflict_cnt, 1);

    contend(8, 0);
    check("count after 8 contended", conflict_cnt, 9);
    contend(300, 0);
    check("count saturated", conflict_cnt, 255);

    txn(0, 1, 8'h20, 8'h55, 3, rd_a);
    bus.i2c_req = 1; bus.i2c_we = 1; bus.i2c_addr = 8'h20; bus.i2c_wdata = 8'hAA;
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    check("mid reset busy",      busy,          0);
    check("mid reset owner",     owner,         0);
    check("mid reset mem_en",    bus.mem_en,    0);
    check("mid reset mem_we",    bus.mem_we,    0);
    check("mid reset mem_addr",  bus.mem_addr,  0);
    check("mid reset mem_wdata", bus.mem_wdata, 0);
    check("mid reset i2c_ack",   bus.i2c_ack,   0);
    check("mid reset i2c_rdata", bus.i2c_rdata, 0);
    check("mid reset cnt",       conflict_cnt,  0);
    bus.i2c_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1;

    fork
      txn(0, 0, 8'h20, 8'h00, 3, rd_a);
      txn(1, 0, 8'h02, 8'h00, 7, rd_b);
    join
    check("aborted write left old value", rd_a, 8'h55);
    check("conflict count after reset", conflict_cnt, 1);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
